// File: rtl/mux_4to1_rr_arbiter_pkg.sv
// Shared types, sizes and the rotate/priority-find helper for the round-robin mux arbiter.
// Optional lock feature is controlled by the MUXARB_LOCK_EN macro in the interface and top.
package mux_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic [0:0] {
    IDLE,
    GRANT
  } state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Searches ptr, ptr+1, ... modulo NUM_REQ; descending loop so the lowest offset wins.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [IDX_W-1:0]   ptr);
    pick_t            res;
    logic [IDX_W-1:0] idx;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr + IDX_W'(i);
      if (req[idx]) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_4to1_rr_arbiter_if.sv
// Request/grant bus plus the shared 4:1 mux data lines; MUXARB_LOCK_EN adds the lock input.
interface mux_arb_if
  import mux_arb_pkg::*;
  ();

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               s0;
  logic               s1;
  logic               busy;
  logic               i0;
  logic               i1;
  logic               i2;
  logic               i3;
  logic               y;

`ifdef MUXARB_LOCK_EN
  logic               lock;

  modport master (
    output req, lock, i0, i1, i2, i3,
    input  gnt, s0, s1, busy, y
  );

  modport slave (
    input  req, lock, i0, i1, i2, i3,
    output gnt, s0, s1, busy, y
  );
`else
  modport master (
    output req, i0, i1, i2, i3,
    input  gnt, s0, s1, busy, y
  );

  modport slave (
    input  req, i0, i1, i2, i3,
    output gnt, s0, s1, busy, y
  );
`endif

endinterface

// File: rtl/mux_4to1_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after the priority pointer.
module mux_arb_rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_idx
);

  pick_t w_pick;

  assign w_pick  = rr_pick(i_req, i_ptr);
  assign o_found = w_pick.found;
  assign o_idx   = w_pick.idx;

endmodule

// File: rtl/mux_4to1_rr_arbiter.sv
// Round-robin arbiter owning the select lines of a shared 4:1 single-bit mux.
// Define MUXARB_LOCK_EN to add a lock input that suppresses burst-expiry release.
module mux_4to1_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic     clk,
  input  logic     rst,
  mux_arb_if.slave bus
);

  localparam int unsigned      CntW   = $clog2(MAX_BURST) + 1;
  localparam logic [CntW-1:0]  CntMax = CntW'(MAX_BURST - 1);

  state_e             r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [IDX_W-1:0]   r_sel;
  logic [CntW-1:0]    r_cnt;
  logic [IDX_W-1:0]   r_ptr;

  state_e             w_state_nxt;
  logic [NUM_REQ-1:0] w_gnt_nxt;
  logic [IDX_W-1:0]   w_sel_nxt;
  logic [CntW-1:0]    w_cnt_nxt;
  logic [IDX_W-1:0]   w_ptr_nxt;

  logic [NUM_REQ-1:0] w_pick_req;
  logic               w_found;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_own_req;
  logic               w_lock;
  logic               w_hold;
  logic [NUM_REQ-1:0] w_din;

`ifdef MUXARB_LOCK_EN
  assign w_lock = bus.lock;
`else
  assign w_lock = 1'b0;
`endif

  // Masking the owner makes any contender win a release; in IDLE r_gnt is zero.
  assign w_pick_req = bus.req & ~r_gnt;
  assign w_own_req  = |(bus.req & r_gnt);
  assign w_hold     = w_own_req && ((r_cnt != CntMax) || w_lock);

  mux_arb_rr_pick u_pick (
    .i_req   (w_pick_req),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_pick_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;

    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = onehot(w_pick_idx);
          w_sel_nxt   = w_pick_idx;
          w_cnt_nxt   = '0;
          w_ptr_nxt   = w_pick_idx + IDX_W'(1);
        end else begin
          w_gnt_nxt   = '0;
        end
      end

      GRANT: begin
        if (w_hold) begin
          // Saturates at CntMax only when lock keeps the tenure alive.
          if (r_cnt != CntMax) begin
            w_cnt_nxt = r_cnt + CntW'(1);
          end
        end else if (w_found) begin
          w_gnt_nxt   = onehot(w_pick_idx);
          w_sel_nxt   = w_pick_idx;
          w_cnt_nxt   = '0;
          w_ptr_nxt   = w_pick_idx + IDX_W'(1);
        end else if (w_own_req) begin
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign w_din    = {bus.i3, bus.i2, bus.i1, bus.i0};
  assign bus.gnt  = r_gnt;
  assign bus.s1   = r_sel[1];
  assign bus.s0   = r_sel[0];
  assign bus.busy = |r_gnt;
  assign bus.y    = w_din[r_sel];

endmodule
